// File: rtl/arbitro_4a1_pkg.sv
// rtl/arbitro_4a1_pkg.sv - shared constants and round-robin pick helper for the 4-lane arbiter
package arbitro_4a1_pkg;

    localparam int DATA_W_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int NUM_LANES      = 4;

    localparam logic [1:0] LAST_GRANT_RST = 2'd3;

    // Returns {found, lane}: first requesting lane searching from last+1, wrapping.
    function automatic logic [2:0] rrPick(input logic [NUM_LANES-1:0] reqMask,
                                          input logic [1:0]           last);
        logic [1:0] cand;
        logic [2:0] pick;
        pick = {1'b0, last};
        for (int k = 1; k <= NUM_LANES; k++) begin
            cand = last + 2'(k);
            if (!pick[2] && reqMask[cand]) begin
                pick = {1'b1, cand};
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/arbitro_4a1_fifo_lane.sv
// rtl/arbitro_4a1_fifo_lane.sv - single-lane FIFO with sticky overflow flag
module fifo_lane
    import arbitro_4a1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W:0]    count;
    logic              doPush;
    logic              doPop;

    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    // Full is judged on the registered count, so a same-edge pop never makes room.
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
            if (push && full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= din;
        end
    end

    assign dout = mem[rdPtr];

endmodule

// File: rtl/arbitro_4a1.sv
// rtl/arbitro_4a1.sv - four lane FIFOs merged round-robin into one registered output
module arbitro_4a1
    import arbitro_4a1_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    input  logic              valid_in0,
    input  logic              valid_in1,
    input  logic              valid_in2,
    input  logic              valid_in3,
    input  logic              ready_out,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        lane_out,
    output logic              valid_out,
    output logic [3:0]        fifo_full,
    output logic [3:0]        fifo_empty,
    output logic [3:0]        overflow,
    output logic              idle_out
);

    logic [DATA_W-1:0]    laneDin  [NUM_LANES];
    logic [DATA_W-1:0]    laneDout [NUM_LANES];
    logic [NUM_LANES-1:0] laneValid;
    logic [NUM_LANES-1:0] lanePop;
    logic [1:0]           lastGrant;
    logic [1:0]           grantLane;
    logic                 grantFound;
    logic                 outFree;
    logic                 doPop;

    assign laneDin[0] = data_in0;
    assign laneDin[1] = data_in1;
    assign laneDin[2] = data_in2;
    assign laneDin[3] = data_in3;
    assign laneValid  = {valid_in3, valid_in2, valid_in1, valid_in0};

    for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
        fifo_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (FIFO_DEPTH)
        ) uLane (
            .clk      (clk),
            .reset_L  (reset_L),
            .push     (laneValid[i]),
            .pop      (lanePop[i]),
            .din      (laneDin[i]),
            .dout     (laneDout[i]),
            .full     (fifo_full[i]),
            .empty    (fifo_empty[i]),
            .overflow (overflow[i])
        );
    end

    // Output slot can take a new word when it is vacant or being consumed this cycle.
    assign outFree = !valid_out || ready_out;
    assign {grantFound, grantLane} = rrPick(~fifo_empty, lastGrant);
    assign doPop   = outFree && grantFound;
    assign lanePop = doPop ? (NUM_LANES'(1) << grantLane) : '0;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            data_out  <= '0;
            lane_out  <= '0;
            valid_out <= 1'b0;
            lastGrant <= LAST_GRANT_RST;
        end else if (outFree) begin
            if (grantFound) begin
                data_out  <= laneDout[grantLane];
                lane_out  <= grantLane;
                valid_out <= 1'b1;
                lastGrant <= grantLane;
            end else begin
                valid_out <= 1'b0;
            end
        end
    end

    assign idle_out = (&fifo_empty) && !valid_out;

endmodule

// File: tb/tb_arbitro_4a1.sv
// tb/tb_arbitro_4a1.sv - randomized and directed bench for arbitro_4a1 against a queue model
module tb_arbitro_4a1;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       ready = 1'b0;
    logic [7:0] din [4];
    logic [3:0] vin;

    logic [7:0] data_out;
    logic [1:0] lane_out;
    logic       valid_out;
    logic [3:0] fifo_full;
    logic [3:0] fifo_empty;
    logic [3:0] overflow;
    logic       idle_out;

    int nCmp = 0;
    int nBad = 0;

    logic [7:0] mq [4][$];
    bit         mValid;
    logic [7:0] mData;
    int         mLane;
    int         mLast;
    logic [3:0] mOvf;

    always #5 clk = ~clk;

    arbitro_4a1 #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .data_in0   (din[0]),
        .data_in1   (din[1]),
        .data_in2   (din[2]),
        .data_in3   (din[3]),
        .valid_in0  (vin[0]),
        .valid_in1  (vin[1]),
        .valid_in2  (vin[2]),
        .valid_in3  (vin[3]),
        .ready_out  (ready),
        .data_out   (data_out),
        .lane_out   (lane_out),
        .valid_out  (valid_out),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .overflow   (overflow),
        .idle_out   (idle_out)
    );

    function automatic logic [23:0] expVec();
        logic [3:0] f;
        logic [3:0] e;
        for (int i = 0; i < 4; i++) begin
            f[i] = (mq[i].size() == DEPTH);
            e[i] = (mq[i].size() == 0);
        end
        return {mValid ? mData : 8'h00, mValid ? 2'(mLane) : 2'd0, mValid,
                f, e, mOvf, (&e) && !mValid};
    endfunction

    function automatic logic [23:0] dutVec();
        return {valid_out ? data_out : 8'h00, valid_out ? lane_out : 2'd0, valid_out,
                fifo_full, fifo_empty, overflow, idle_out};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        mValid = 0;
        mData  = 8'h00;
        mLane  = 0;
        mLast  = 3;
        mOvf   = 4'h0;
    endtask

    task automatic clearInputs();
        vin = 4'h0;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
    endtask

    // One clock: the model applies the edge from pre-edge state, then we return at the negedge.
    task automatic tick();
        int sz [4];
        int pl;
        bit fr;
        @(posedge clk);
        for (int i = 0; i < 4; i++) sz[i] = mq[i].size();
        fr = !mValid || ready;
        pl = -1;
        if (fr) begin
            for (int k = 1; k <= 4; k++) begin
                if (pl < 0 && sz[(mLast + k) % 4] > 0) pl = (mLast + k) % 4;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (vin[i]) begin
                if (sz[i] < DEPTH) mq[i].push_back(din[i]);
                else mOvf[i] = 1'b1;
            end
        end
        if (fr) begin
            if (pl >= 0) begin
                mData  = mq[pl].pop_front();
                mLane  = pl;
                mValid = 1;
                mLast  = pl;
            end else begin
                mValid = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset_L = 1'b0;
        ready   = 1'b0;
        clearInputs();
        modelReset();
        @(negedge clk);
        reset_L = 1'b1;
    endtask

    task automatic test_reset();
        reset_L = 1'b0;
        clearInputs();
        modelReset();
        repeat (2) @(negedge clk);
        nCmp++;
        if ({data_out, lane_out, valid_out, fifo_full, fifo_empty, overflow, idle_out}
            !== {8'h00, 2'd0, 1'b0, 4'h0, 4'hF, 4'h0, 1'b1}) begin
            nBad++;
            $display("FAIL reset_state: got %h expected %h",
                     {data_out, lane_out, valid_out, fifo_full, fifo_empty, overflow, idle_out},
                     {8'h00, 2'd0, 1'b0, 4'h0, 4'hF, 4'h0, 1'b1});
        end
        reset_L = 1'b1;
        tick();
        nCmp++;
        if (dutVec() !== expVec()) begin
            nBad++;
            $display("FAIL reset_release_idle: got %h expected %h", dutVec(), expVec());
        end
    endtask

    task automatic test_single_write();
        applyReset();
        ready  = 1'b1;
        din[2] = 8'hA5;
        vin[2] = 1'b1;
        tick();
        clearInputs();
        tick();
        nCmp++;
        if ({data_out, lane_out, valid_out} !== {8'hA5, 2'd2, 1'b1}) begin
            nBad++;
            $display("FAIL single_write_out: got %h/%0d/%b expected a5/2/1",
                     data_out, lane_out, valid_out);
        end
        tick();
        nCmp++;
        if (idle_out !== 1'b1 || dutVec() !== expVec()) begin
            nBad++;
            $display("FAIL single_write_idle: got %h expected %h", dutVec(), expVec());
        end
    endtask

    task automatic test_fairness();
        applyReset();
        ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            for (int i = 0; i < 4; i++) begin
                vin[i] = (c < 4);
                din[i] = 8'(8'h10 * i + c);
            end
            tick();
            if (c >= 1 && c <= 16) begin
                nCmp++;
                if (lane_out !== 2'((c - 1) % 4) || valid_out !== 1'b1 ||
                    data_out !== 8'(8'h10 * ((c - 1) % 4) + (c - 1) / 4)) begin
                    nBad++;
                    $display("FAIL fairness_order c=%0d: got %h/%0d/%b expected %h/%0d/1", c,
                             data_out, lane_out, valid_out,
                             8'(8'h10 * ((c - 1) % 4) + (c - 1) / 4), (c - 1) % 4);
                end
            end
            nCmp++;
            if (dutVec() !== expVec()) begin
                nBad++;
                $display("FAIL fairness_model c=%0d: got %h expected %h", c, dutVec(), expVec());
            end
        end
    endtask

    task automatic test_backpressure();
        applyReset();
        ready  = 1'b0;
        vin[1] = 1'b1;
        din[1] = 8'h11;
        tick();
        din[1] = 8'h12;
        tick();
        clearInputs();
        for (int c = 0; c < 6; c++) begin
            tick();
            nCmp++;
            if (data_out !== 8'h11 || valid_out !== 1'b1 || lane_out !== 2'd1) begin
                nBad++;
                $display("FAIL backpressure_hold c=%0d: got %h/%b expected 11/1", c, data_out, valid_out);
            end
        end
        ready = 1'b1;
        tick();
        nCmp++;
        if (data_out !== 8'h12 || valid_out !== 1'b1) begin
            nBad++;
            $display("FAIL backpressure_next: got %h/%b expected 12/1", data_out, valid_out);
        end
        tick();
        nCmp++;
        if (dutVec() !== expVec() || valid_out !== 1'b0) begin
            nBad++;
            $display("FAIL backpressure_drain: got %h expected %h", dutVec(), expVec());
        end
    endtask

    task automatic test_overflow();
        applyReset();
        ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            vin[3] = 1'b1;
            din[3] = 8'(8'h31 + c);
            tick();
            nCmp++;
            if (dutVec() !== expVec()) begin
                nBad++;
                $display("FAIL overflow_fill c=%0d: got %h expected %h", c, dutVec(), expVec());
            end
        end
        clearInputs();
        nCmp++;
        if (overflow !== 4'b1000 || fifo_full !== 4'b1000 || data_out !== 8'h31) begin
            nBad++;
            $display("FAIL overflow_flag: got ovf=%b full=%b data=%h expected 1000/1000/31",
                     overflow, fifo_full, data_out);
        end
        ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            nCmp++;
            if (c < 4 ? (data_out !== 8'(8'h32 + c) || valid_out !== 1'b1)
                      : (valid_out !== 1'b0 || overflow !== 4'b1000)) begin
                nBad++;
                $display("FAIL overflow_drain c=%0d: got %h/%b ovf=%b", c, data_out, valid_out, overflow);
            end
        end
    endtask

    task automatic test_reset_mid();
        applyReset();
        ready = 1'b0;
        vin   = 4'b0111;
        din[0] = 8'h01;
        din[1] = 8'h02;
        din[2] = 8'h03;
        tick();
        vin    = 4'b0001;
        din[0] = 8'h04;
        tick();
        clearInputs();
        #2;
        reset_L = 1'b0;
        modelReset();
        #1;
        nCmp++;
        if (valid_out !== 1'b0 || fifo_empty !== 4'hF || idle_out !== 1'b1) begin
            nBad++;
            $display("FAIL reset_mid_async: got valid=%b empty=%h idle=%b expected 0/f/1",
                     valid_out, fifo_empty, idle_out);
        end
        @(negedge clk);
        reset_L = 1'b1;
        ready   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            nCmp++;
            if (dutVec() !== expVec() || valid_out !== 1'b0) begin
                nBad++;
                $display("FAIL reset_mid_stale c=%0d: got %h expected %h", c, dutVec(), expVec());
            end
        end
    endtask

    task automatic test_random();
        applyReset();
        for (int c = 0; c < 600; c++) begin
            vin   = 4'($urandom) & 4'($urandom);
            ready = ($urandom_range(0, 3) != 0) || (c >= 560);
            for (int i = 0; i < 4; i++) din[i] = 8'($urandom);
            if (c >= 540) vin = 4'h0;
            tick();
            nCmp++;
            if (dutVec() !== expVec()) begin
                nBad++;
                $display("FAIL random c=%0d: got %h expected %h", c, dutVec(), expVec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fairness();
        test_backpressure();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
        $finish;
    end

endmodule
